// File: rtl/handshake_pkg.sv
// rtl/handshake_pkg.sv - shared state encoding and occupancy constants for the skid slice
package handshake_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_BUSY  = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

endpackage

// File: rtl/handshake_skid_if.sv
// rtl/handshake_skid_if.sv - valid/ready bundle seen on both sides of the skid slice
interface handshake_skid_if #(
  parameter int WIDTH = 32
);

  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] data_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] data_o;
  logic [1:0]       occ_o;

  // The slice itself: takes words from the master side, presents them to the slave side.
  modport slave (
    input  valid_i,
    input  data_i,
    input  ready_i,
    output ready_o,
    output valid_o,
    output data_o,
    output occ_o
  );

  // Whatever drives the slice and consumes its output.
  modport master (
    output valid_i,
    output data_i,
    output ready_i,
    input  ready_o,
    input  valid_o,
    input  data_o,
    input  occ_o
  );

endinterface

// File: rtl/handshake_skid.sv
// rtl/handshake_skid.sv - full-throughput register slice with registered ready and two-entry skid
module handshake_skid
  import handshake_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  handshake_skid_if.slave   bus
);

  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic [WIDTH-1:0] skid_q,  skid_d;
  logic [1:0]       occ;

  logic in_xfer;
  logic out_xfer;

  // Transfers are judged against the registered handshake outputs only.
  assign in_xfer  = bus.valid_i && ready_q;
  assign out_xfer = valid_q && bus.ready_i;

  // Next-state and datapath selection; ready is precomputed from the next state so it can be a flop.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    data_d  = data_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          data_d  = bus.data_i;
          valid_d = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_xfer && out_xfer) begin
          data_d = bus.data_i;
        end else if (in_xfer) begin
          // Slave stalled with a word already in flight: park it in the skid register.
          skid_d  = bus.data_i;
          state_d = FULL;
        end else if (out_xfer) begin
          valid_d = 1'b0;
          data_d  = '0;
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          data_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: begin
        state_d = EMPTY;
        valid_d = 1'b0;
        data_d  = '0;
      end
    endcase
    ready_d = (state_d != FULL);
  end

  // State and datapath registers; reset drops any held words.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      data_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      data_q  <= data_d;
      skid_q  <= skid_d;
    end
  end

  // Occupancy is a pure decode of the registered state.
  always_comb begin
    occ = OCC_EMPTY;
    case (state_q)
      EMPTY:   occ = OCC_EMPTY;
      BUSY:    occ = OCC_BUSY;
      FULL:    occ = OCC_FULL;
      default: occ = OCC_EMPTY;
    endcase
  end

  assign bus.valid_o = valid_q;
  assign bus.ready_o = ready_q;
  assign bus.data_o  = data_q;
  assign bus.occ_o   = occ;

endmodule
